// File: rtl/fir_128_mdc_job_sequencer.sv
// Job-level sequencer for fir_128_mdc: runs N_ITER iterations of LEN samples per trigger.
// Optional per-iteration watchdog enabled by defining FIR_128_MDC_SEQ_TIMEOUT_EN.
module fir_128_mdc_job_sequencer #(
  parameter int CNT_WIDTH      = 32,
  parameter int ITER_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  trigger_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic [ITER_WIDTH-1:0] n_iter_i,
  output logic                  engine_start_o,
  output logic                  engine_clear_o,
  input  logic                  engine_ready_i,
  input  logic [CNT_WIDTH-1:0]  engine_cnt_i,
  output logic                  x_start_o,
  input  logic                  x_done_i,
  output logic                  y_start_o,
  input  logic                  y_done_i,
  output logic                  busy_o,
  output logic                  evt_o,
  output logic [ITER_WIDTH-1:0] iter_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_NEXT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [ITER_WIDTH-1:0] r_n_iter;
  logic [ITER_WIDTH-1:0] r_iter;
  logic                  r_x_seen;
  logic                  r_y_seen;
  logic                  r_busy;
  logic                  r_evt;
  logic                  r_eng_start;
  logic                  r_eng_clear;
  logic                  r_x_start;
  logic                  r_y_start;
  logic                  r_err;

  logic                  w_x_seen;
  logic                  w_y_seen;
  logic                  w_done;
  logic                  w_last;
  logic                  w_wd_expired;
  logic [ITER_WIDTH-1:0] w_iter_nxt;

  // A done pulse in the same cycle as the completion check counts immediately.
  assign w_x_seen   = r_x_seen | x_done_i;
  assign w_y_seen   = r_y_seen | y_done_i;
  assign w_done     = w_x_seen & w_y_seen & (engine_cnt_i >= r_len);
  assign w_iter_nxt = r_iter + 1'b1;
  assign w_last     = (w_iter_nxt == r_n_iter);

`ifdef FIR_128_MDC_SEQ_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] r_wd;

  assign w_wd_expired = (r_wd == WD_LIMIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd <= '0;
    end else if (clear_i || r_state == S_START) begin
      r_wd <= '0;
    end else if (r_state == S_RUN) begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign w_wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_n_iter    <= '0;
      r_iter      <= '0;
      r_x_seen    <= 1'b0;
      r_y_seen    <= 1'b0;
      r_busy      <= 1'b0;
      r_evt       <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_clear <= 1'b0;
      r_x_start   <= 1'b0;
      r_y_start   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      r_x_start   <= 1'b0;
      r_y_start   <= 1'b0;
      r_evt       <= 1'b0;
      r_eng_clear <= 1'b0;
      if (clear_i) begin
        r_state     <= S_IDLE;
        r_eng_clear <= 1'b1;
        r_busy      <= 1'b0;
        r_x_seen    <= 1'b0;
        r_y_seen    <= 1'b0;
        r_iter      <= '0;
        r_err       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (trigger_i && engine_ready_i) begin
              r_len    <= len_i;
              r_n_iter <= n_iter_i;
              r_iter   <= '0;
              r_err    <= 1'b0;
              r_busy   <= 1'b1;
              // Empty jobs complete immediately without touching the streamers.
              if (len_i == '0 || n_iter_i == '0) begin
                r_state     <= S_FIN;
                r_evt       <= 1'b1;
                r_eng_clear <= 1'b1;
              end else begin
                r_state     <= S_START;
                r_eng_start <= 1'b1;
                r_x_start   <= 1'b1;
                r_y_start   <= 1'b1;
              end
            end
          end
          S_START: begin
            r_x_seen <= 1'b0;
            r_y_seen <= 1'b0;
            r_state  <= S_RUN;
          end
          S_RUN: begin
            r_x_seen <= w_x_seen;
            r_y_seen <= w_y_seen;
            if (w_done) begin
              r_iter      <= w_iter_nxt;
              r_eng_clear <= 1'b1;
              if (w_last) begin
                r_state <= S_FIN;
                r_evt   <= 1'b1;
              end else begin
                r_state <= S_NEXT;
              end
            end else if (w_wd_expired) begin
              r_err       <= 1'b1;
              r_state     <= S_FIN;
              r_evt       <= 1'b1;
              r_eng_clear <= 1'b1;
            end
          end
          S_NEXT: begin
            // The first NEXT cycle carries the clear; ready is only trusted afterwards.
            if (!r_eng_clear && engine_ready_i) begin
              r_state     <= S_START;
              r_eng_start <= 1'b1;
              r_x_start   <= 1'b1;
              r_y_start   <= 1'b1;
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign engine_start_o = r_eng_start;
  assign engine_clear_o = r_eng_clear;
  assign x_start_o      = r_x_start;
  assign y_start_o      = r_y_start;
  assign busy_o         = r_busy;
  assign evt_o          = r_evt;
  assign iter_o         = r_iter;
  assign err_o          = r_err;

endmodule

// File: tb/tb_fir_128_mdc_job_sequencer.sv
// Directed bench for fir_128_mdc_job_sequencer; stimulus driven 1 ns after each rising edge.
// Watchdog case follows FIR_128_MDC_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=16.
module tb_fir_128_mdc_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        trig;
  logic [31:0] len;
  logic [15:0] n_iter;
  logic        eng_start;
  logic        eng_clear;
  logic        ready;
  logic [31:0] cnt;
  logic        x_start;
  logic        xd;
  logic        y_start;
  logic        yd;
  logic        busy;
  logic        evt;
  logic [15:0] iter;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int n_xs = 0, n_ys = 0, n_es = 0, n_evt = 0, n_clr_only = 0;
  int b_xs, b_evt, b_clr;
  bit ok;

  fir_128_mdc_job_sequencer #(
    .CNT_WIDTH(32), .ITER_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .trigger_i(trig),
    .len_i(len), .n_iter_i(n_iter),
    .engine_start_o(eng_start), .engine_clear_o(eng_clear),
    .engine_ready_i(ready), .engine_cnt_i(cnt),
    .x_start_o(x_start), .x_done_i(xd), .y_start_o(y_start), .y_done_i(yd),
    .busy_o(busy), .evt_o(evt), .iter_o(iter), .err_o(err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (x_start)           n_xs++;
    if (y_start)           n_ys++;
    if (eng_start)         n_es++;
    if (evt)               n_evt++;
    if (eng_clear && !evt) n_clr_only++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (x_start) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic fire(input logic [31:0] l, input logic [15:0] n);
    len = l; n_iter = n; trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; trig = 1'b0; len = '0; n_iter = '0;
    ready = 1'b1; cnt = '0; xd = 1'b0; yd = 1'b0;
    #12;
    chk("reset_outputs", {9'd0, busy, evt, eng_start, eng_clear, x_start, y_start, err, iter}, 32'd0);
    rst_n = 1'b1;
    tick();

    // len=128, n_iter=1 with hand-placed done pulses
    b_xs = n_xs; b_evt = n_evt;
    fire(32'd128, 16'd1);
    chk("t1_starts", {29'd0, eng_start, x_start, y_start}, 32'h7);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_start_one_cycle", {29'd0, eng_start, x_start, y_start}, 32'h0);
    repeat (59) tick();
    xd = 1'b1; tick(); xd = 1'b0;
    repeat (79) tick();
    yd = 1'b1; tick(); yd = 1'b0;
    cnt = 32'd128;
    chk("t1_evt_early", evt, 0);
    tick();
    chk("t1_evt", evt, 1);
    chk("t1_iter", iter, 32'd1);
    chk("t1_fin_clear", eng_clear, 1);
    cnt = '0;
    tick();
    chk("t1_evt_one_cycle", evt, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_start_count", n_xs - b_xs, 32'd1);
    chk("t1_evt_count", n_evt - b_evt, 32'd1);

    // len=16, n_iter=3: three start triples, two NEXT clears, one event
    b_xs = n_xs; b_evt = n_evt; b_clr = n_clr_only;
    fire(32'd16, 16'd3);
    for (int it = 0; it < 3; it++) begin
      wait_start(ok);
      chk("t2_start_seen", {31'd0, ok}, 32'd1);
      chk("t2_start_triple", {29'd0, eng_start, x_start, y_start}, 32'h7);
      tick(); tick(); tick();
      xd = 1'b1; yd = 1'b1; cnt = 32'd16;
      tick();
      xd = 1'b0; yd = 1'b0;
      if (it < 2) begin
        chk("t2_next_clear", {30'd0, eng_clear, evt}, 32'h2);
        chk("t2_iter_mid", iter, it + 1);
        cnt = '0;
        tick();
      end else begin
        chk("t2_evt", evt, 1);
        chk("t2_iter_final", iter, 32'd3);
        cnt = '0;
      end
    end
    tick();
    chk("t2_busy_low", busy, 0);
    chk("t2_start_count", n_xs - b_xs, 32'd3);
    chk("t2_next_clears", n_clr_only - b_clr, 32'd2);
    chk("t2_evt_count", n_evt - b_evt, 32'd1);

    // y_done before x_done, count already satisfied
    fire(32'd8, 16'd1);
    tick();
    cnt = 32'd8;
    tick();
    yd = 1'b1; tick(); yd = 1'b0;
    tick();
    xd = 1'b1;
    chk("t3_evt_before_x", evt, 0);
    tick();
    xd = 1'b0;
    chk("t3_evt_after_x", evt, 1);
    cnt = '0;
    tick();
    // x_done and y_done together
    fire(32'd8, 16'd1);
    tick();
    xd = 1'b1; yd = 1'b1; cnt = 32'd9;
    tick();
    xd = 1'b0; yd = 1'b0;
    chk("t3_same_cycle_evt", evt, 1);
    cnt = '0;
    tick();
    chk("t3_busy_low", busy, 0);

    // empty jobs and triggers while the engine is not ready
    b_xs = n_xs;
    fire(32'd0, 16'd5);
    chk("t4_len0_evt", evt, 1);
    chk("t4_len0_busy", busy, 1);
    tick();
    chk("t4_len0_evt_gone", evt, 0);
    fire(32'd4, 16'd0);
    chk("t4_niter0_evt", evt, 1);
    tick();
    chk("t4_no_starts", n_xs - b_xs, 32'd0);
    ready = 1'b0;
    fire(32'd4, 16'd1);
    chk("t4_not_ready_busy", busy, 0);
    tick();
    chk("t4_not_ready_busy2", busy, 0);
    ready = 1'b1;

    // soft clear mid-RUN after one finished iteration; stray trigger while busy
    b_xs = n_xs; b_evt = n_evt;
    fire(32'd16, 16'd2);
    tick(); tick();
    trig = 1'b1; len = 32'd0; tick(); trig = 1'b0;
    chk("t5_trig_ignored_busy", busy, 1);
    xd = 1'b1; yd = 1'b1; cnt = 32'd16;
    tick();
    xd = 1'b0; yd = 1'b0; cnt = '0;
    chk("t5_iter_one", iter, 32'd1);
    tick();
    wait_start(ok);
    chk("t5_second_start", {31'd0, ok}, 32'd1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clear_state", {27'd0, busy, evt, eng_clear, x_start, eng_start}, 32'h4);
    chk("t5_clear_iter", iter, 32'd0);
    tick();
    chk("t5_clear_pulse_end", eng_clear, 0);
    repeat (5) tick();
    chk("t5_no_evt", n_evt - b_evt, 32'd0);
    chk("t5_start_count", n_xs - b_xs, 32'd2);

    // async reset mid-job
    b_evt = n_evt;
    fire(32'd16, 16'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_reset", {9'd0, busy, evt, eng_start, eng_clear, x_start, y_start, err, iter}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t5_after_reset_busy", busy, 0);
    chk("t5_reset_no_evt", n_evt - b_evt, 32'd0);

    // x_done never arrives
    fire(32'd8, 16'd1);
    chk("t6_start", x_start, 1);
`ifdef FIR_128_MDC_SEQ_TIMEOUT_EN
    repeat (16) tick();
    chk("t6_wd_evt_early", evt, 0);
    tick();
    chk("t6_wd_evt", evt, 1);
    chk("t6_wd_err", err, 1);
    chk("t6_wd_iter", iter, 32'd0);
    tick();
    chk("t6_wd_busy_low", busy, 0);
    chk("t6_wd_err_sticky", err, 1);
`else
    repeat (40) tick();
    chk("t6_hang_busy", busy, 1);
    chk("t6_hang_err", err, 0);
    chk("t6_hang_evt", evt, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t6_clear_exit", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
